instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage directly upstream of the instruction decoder. Holds the fetch PC and issues word requests to instruction memory over a req/ready handshake. Latches the returned word into an instruction register that drives the decoder's instruction and control-override inputs. Supports pipeline stall and control-flow redirect from JAL/JALR/branch resolution.

Parameters:
N, 32, PC / address bus width
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble word (ADDI x0,x0,0) loaded into the instruction register when empty

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
imem_req  output  1  fetch request to instruction memory
imem_addr  output  N  word-aligned fetch address
imem_ready  input  1  memory has data for the current request this cycle
imem_rdata  input  32  returned instruction word, valid when imem_ready=1
stall  input  1  downstream not ready to consume instr
redirect  input  1  load new fetch PC (jump/branch taken)
redirect_pc  input  N  redirect target
instr  output  32  instruction register, to decoder instr
pc  output  N  address of word held in instr
instr_valid  output  1  instr holds a real fetched instruction
control_override  output  1  equals ~instr_valid, to decoder controlOverride
fetch_fault  output  1  sticky: misaligned redirect seen
instr_count  output  32  number of instructions consumed downstream

Behaviour:
- Reset (rst_n=0 at rising edge) applies the following regardless of state:
  - state=REQ, fetch_pc=RESET_PC, instr=NOP_INSTR, pc=RESET_PC.
  - instr_valid=0, fetch_fault=0, instr_count=0.
  - imem_req=0 during the reset cycle.
- imem_req and imem_addr are combinational from state:
  - imem_req=1 only in REQ while rst_n=1.
  - imem_addr=fetch_pc in every state.
- State REQ:
  - redirect=1: fetch_pc<=redirect_pc with bits[1:0] forced to 0. If redirect_pc[1:0]!=0, fetch_fault<=1. Any same-cycle imem_ready/rdata is discarded. Stay in REQ.
  - Otherwise, if imem_ready=1: instr<=imem_rdata, pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^N, wraps). Go to HOLD.
  - Otherwise, stay in REQ; the request is held with a stable address.
- State HOLD (imem_req=0):
  - redirect=1 (priority over stall): fetch_pc<=aligned redirect_pc, fault rule as above. instr<=NOP_INSTR, instr_valid<=0. Go to REQ. instr_count is not incremented; the held instruction is squashed.
  - Otherwise, if stall=0: the instruction is consumed. instr_count<=instr_count+1 (wraps), instr<=NOP_INSTR, instr_valid<=0. Go to REQ.
  - Otherwise (stall=1): hold instr, pc and instr_valid unchanged.
- Latency and throughput:
  - Minimum 2 cycles per instruction (REQ with ready, then HOLD with stall=0).
  - instr is valid the cycle after imem_ready.
- control_override is derived from the register (~instr_valid), so the decoder sees ADD whenever a bubble is present.
- fetch_fault has no effect on fetching; it clears only on reset.
- Reset mid-request: the outstanding request is abandoned and no rdata is captured that cycle.
- N other than 32: pc, fetch_pc and redirect_pc are N bits; instr stays 32 bits.

Test Plan:
- Reset then imem_ready=1 every cycle, stall=0, memory returns addr-based words -> imem_addr 0,4,8,C on alternate cycles; instr matches each word one cycle after its REQ; instr_count=4 after 8 cycles.
- imem_ready delayed 3 cycles at addr 0x4 -> imem_req held 3 cycles with imem_addr=0x4; instr_valid=0 and control_override=1 throughout; capture on the 4th cycle.
- Instruction 0x00500093 held with stall=1 for 5 cycles -> instr, pc and instr_valid stable; instr_count unchanged; then stall=0 -> count+1, instr=0x00000013.
- Redirect to 0x100 in HOLD with stall=1 -> instr=NOP, instr_valid=0; next imem_addr=0x100; instr_count unchanged.
- Redirect to 0x102 in REQ with imem_ready=1 the same cycle -> rdata discarded; next imem_addr=0x100; fetch_fault=1 stays set until rst_n=0.
- fetch_pc=0xFFFF_FFFC, fetch completes -> next imem_addr=0x0000_0000. Then rst_n=0 mid-REQ -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: issues word requests to instruction memory and holds the fetched
// word in an instruction register feeding the decoder, with stall and redirect.
module instr_fetch #(
    parameter int          N         = 32,
    parameter logic [N-1:0] RESET_PC  = '0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic [31:0]  instr,
    output logic [N-1:0] pc,
    output logic         instr_valid,
    output logic         control_override,
    output logic         fetch_fault,
    output logic [31:0]  instr_count
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] pc_q, pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         fetch_fault_q, fetch_fault_d;
    logic [31:0]  instr_count_q, instr_count_d;

    logic [N-1:0] redirect_aligned;
    logic         redirect_misaligned;

    assign redirect_aligned    = {redirect_pc[N-1:2], 2'b00};
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = fetch_fault_q;
        instr_count_d = instr_count_q;

        unique case (state_q)
            REQ: begin
                // A redirect wins over a same-cycle memory response, which is dropped.
                if (redirect) begin
                    fetch_pc_d    = redirect_aligned;
                    fetch_fault_d = fetch_fault_q | redirect_misaligned;
                end else if (imem_ready) begin
                    instr_d       = imem_rdata;
                    pc_d          = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    fetch_pc_d    = fetch_pc_q + N'(4);
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                // Redirect squashes the held word without counting it as consumed.
                if (redirect) begin
                    fetch_pc_d    = redirect_aligned;
                    fetch_fault_d = fetch_fault_q | redirect_misaligned;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end else if (!stall) begin
                    instr_count_d = instr_count_q + 32'd1;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= REQ;
            fetch_pc_q    <= RESET_PC;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign imem_req         = (state_q == REQ) && rst_n;
    assign imem_addr        = fetch_pc_q;
    assign instr            = instr_q;
    assign pc               = pc_q;
    assign instr_valid      = instr_valid_q;
    assign control_override = ~instr_valid_q;
    assign fetch_fault      = fetch_fault_q;
    assign instr_count      = instr_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the fetch register.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        control_override;
    logic        fetch_fault;
    logic [31:0] instr_count;

    int tests = 0;
    int fails = 0;

    // Model: "holding" means one fetched word is waiting to be consumed.
    bit          m_holding;
    logic [31:0] m_fpc, m_instr, m_pc, m_cnt;
    bit          m_fault;
    bit          m_rst_n;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .instr            (instr),
        .pc               (pc),
        .instr_valid      (instr_valid),
        .control_override (control_override),
        .fetch_fault      (fetch_fault),
        .instr_count      (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rn, input bit rdy, input logic [31:0] rdata,
                              input bit stl, input bit rd, input logic [31:0] rpc);
        m_rst_n = rn;
        if (!rn) begin
            m_holding = 0; m_fpc = 0; m_instr = NOP; m_pc = 0; m_fault = 0; m_cnt = 0;
        end else begin
            if (rd) begin
                m_fpc = rpc & ~32'd3;
                if (rpc[1:0] != 2'b00) m_fault = 1;
                if (m_holding) begin
                    m_instr = NOP; m_holding = 0;
                end
            end else if (!m_holding) begin
                if (rdy) begin
                    m_instr = rdata; m_pc = m_fpc; m_fpc = m_fpc + 32'd4; m_holding = 1;
                end
            end else if (!stl) begin
                m_cnt = m_cnt + 32'd1; m_instr = NOP; m_holding = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, (!m_holding && m_rst_n)});
        chk("imem_addr", imem_addr, m_fpc);
        chk("instr", instr, m_instr);
        chk("pc", pc, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
        chk("control_override", {31'd0, control_override}, {31'd0, !m_holding});
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("instr_count", instr_count, m_cnt);
    endtask

    // One clock: drive inputs, advance the model, check 1 time unit after the edge.
    task automatic cyc(input bit rn, input bit rdy, input logic [31:0] rdata,
                       input bit stl, input bit rd, input logic [31:0] rpc);
        rst_n = rn; imem_ready = rdy; imem_rdata = rdata;
        stall = stl; redirect = rd; redirect_pc = rpc;
        model_step(rn, rdy, rdata, stl, rd, rpc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 0; imem_ready = 0; imem_rdata = 0; stall = 0; redirect = 0; redirect_pc = 0;
        m_rst_n = 0; m_holding = 0; m_fpc = 0; m_instr = NOP; m_pc = 0; m_fault = 0; m_cnt = 0;

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("reset_instr", instr, NOP);
        chk("reset_req", {31'd0, imem_req}, 32'd0);

        // Back-to-back fetches with an address-derived memory image.
        for (int i = 0; i < 8; i++) cyc(1, 1, {16'hC0DE, m_fpc[15:0]}, 0, 0, 0);
        chk("count_after_8", instr_count, 32'd4);
        chk("addr_after_8", imem_addr, 32'h10);

        // Delayed ready at 0x4.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h1111_0000, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 32'hBAD0_0000, 0, 0, 0);
            chk("wait_addr", imem_addr, 32'h4);
            chk("wait_override", {31'd0, control_override}, 32'd1);
        end
        cyc(1, 1, 32'h0050_0093, 1, 0, 0);
        chk("capture_instr", instr, 32'h0050_0093);
        chk("capture_pc", pc, 32'h4);

        // Stall holds the word, release consumes it.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 0);
        chk("stall_count", instr_count, 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("consume_count", instr_count, 32'd2);
        chk("consume_nop", instr, NOP);

        // Redirect in HOLD while stalled squashes the word.
        cyc(1, 1, 32'h2222_2222, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 32'h100);
        chk("squash_addr", imem_addr, 32'h100);
        chk("squash_count", instr_count, 32'd2);

        // Misaligned redirect in REQ with same-cycle ready.
        cyc(1, 1, 32'h3333_3333, 0, 1, 32'h102);
        chk("misalign_addr", imem_addr, 32'h100);
        chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        chk("misalign_valid", {31'd0, instr_valid}, 32'd0);

        // Address wrap at the top of the space, then reset mid-request.
        cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(1, 1, 32'h4444_4444, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h5555_5555, 0, 0, 0);
        chk("midreset_instr", instr, NOP);
        chk("midreset_fault", {31'd0, fetch_fault}, 32'd0);
        chk("midreset_count", instr_count, 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            cyc(($urandom % 60) != 0, ($urandom % 3) == 0, $urandom,
                ($urandom % 2) == 0, ($urandom % 8) == 0, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
